player_move: RTL and testbench
==============================

// Module: player_move
// PURPOSE
//  Per-stage player position controller: the reading side of the maze wall map that the renderer draws.
//  On each move_tick it takes one key direction and forms a candidate position.
//  It probes the shared map ROM for the 4 corners of the player box, one lookup at a time.
//  It commits the move only if all corners are open, and flags reaching the right-edge exit.
//  Coordinates are maze-local pixels (0..204, 5 px per cell, 41x41 cells); the renderer adds the screen offset.
// PARAMETERS
//  PLAYER_SIZE  4    player box edge in maze pixels
//  STEP         1    pixels moved per accepted tick
//  START_X      5    x reloaded on reset/stage entry
//  START_Y      5    y reloaded on reset/stage entry
//  EXIT_X       200  goal when committed x+PLAYER_SIZE-1 >= EXIT_X
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  async active-low reset
//  state      in   4  game state; STAGE1=2, STAGE2=4, STAGE3=6 enable movement
//  move_tick  in   1  1-cycle movement strobe
//  key_up/key_down/key_left/key_right in 1 each  held direction keys
//  map_req    out  1  map lookup request, 1 cycle per probe
//  map_row    out  6  cell row = y/5 of probed corner
//  map_col    out  6  cell col = x/5 of probed corner
//  map_wall   in   1  wall bit for the request issued the previous cycle
//  player_x   out  8  committed x
//  player_y   out  8  committed y
//  busy       out  1  high in any state other than IDLE
//  blocked    out  1  1-cycle pulse: move rejected
//  goal       out  1  1-cycle pulse: committed move reached the exit
// BEHAVIOUR
//  Reset (async, rst_n=0): player_x=START_X, player_y=START_Y, FSM=IDLE; map_req, busy, blocked, goal = 0; row/col=0.
//  FSM: IDLE -> PROBEk -> WAITk (k=0..3) -> COMMIT -> IDLE. map_req=1 only in PROBEk.
//  IDLE: if state is a stage, move_tick=1 and any key is held, latch the candidate and go to PROBE0.
//  Key priority: up > down > left > right. Only one axis moves per tick.
//  Candidate: up y-STEP, down y+STEP, left x-STEP, right x+STEP; computed at 9 bits.
//  Negative candidate, or candidate+PLAYER_SIZE-1 > 204: blocked pulse and stay IDLE. No probe is issued.
//  Corner order: k0 (x,y), k1 (x+S-1,y), k2 (x,y+S-1), k3 (x+S-1,y+S-1); S=PLAYER_SIZE.
//  WAITk: sample map_wall. If 1, go to IDLE, pulse blocked next cycle, position unchanged (early abort).
//  WAITk with map_wall=0: go to PROBEk+1, or to COMMIT after k3.
//  COMMIT: register candidate into player_x/y. goal=1 for the same cycle if cand_x+S-1 >= EXIT_X.
//  Timing: tick sampled at edge E0; full success makes the new position visible after edge E9.
//  Timing: a wall at corner k raises blocked after edge E(2k+2).
//  move_tick while busy: ignored, not queued.
//  Keys are sampled only at the accepted tick; later key changes do not affect that move.
//  Stage entry: state changes to a stage value different from its last-cycle value.
//  On stage entry, reload START_X/Y and force IDLE, aborting any probe; no blocked/goal pulse.
//  Non-stage state: FSM held IDLE, ticks ignored, position held.
//  Division by 5: combinational divide or constant-multiply; result must be exact for 0..204.
// TESTING
//  T1 Reset asserted mid-run -> x=5, y=5, busy=0, map_req=0 immediately (async), no pulses.
//  T2 state=2, right + tick, open map stub -> 4 reqs (r1c1, r1c1, r1c1, r1c1), x=6 after edge E9.
//  T3 From (5,5): up + tick, stub wall at row 0 -> one req (r0c1), blocked after E2, y stays 5.
//  T4 up+right held + tick -> only y changes (y=4 if open); x unchanged.
//  T5 START_X=196, START_Y=96: right + tick, row19 col40 open -> x=197, goal pulses one cycle.
//  T6 state 2->4 during PROBE2 -> position reloads to (5,5) next edge, busy=0, no blocked/goal.

Source files
------------

// File: rtl/player_move.sv
// player_move: per-stage player position controller; probes four box corners in the maze map before committing a move.
module player_move #(
  parameter int PLAYER_SIZE = 4,
  parameter int STEP = 1,
  parameter int START_X = 5,
  parameter int START_Y = 5,
  parameter int EXIT_X = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       move_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       map_req,
  output logic [5:0] map_row,
  output logic [5:0] map_col,
  input  logic       map_wall,
  output logic [7:0] player_x,
  output logic [7:0] player_y,
  output logic       busy,
  output logic       blocked,
  output logic       goal
);
  typedef enum logic [3:0] {
    IDLE, PROBE0, WAIT0, PROBE1, WAIT1, PROBE2, WAIT2, PROBE3, WAIT3, COMMIT
  } fsm_t;
  fsm_t fsm, fsm_nx;
  logic [3:0] prev_state;
  logic [7:0] cand_x, cand_y, px, py;
  logic [9:0] x10, y10, step, nx, ny;
  logic [1:0] k;
  logic stage, entry, any_key, oob, blk_nx, goal_nx;
  // exact for 0..204: v*205/1024 never drifts past the next multiple of 5
  function automatic logic [5:0] div5(input logic [7:0] v);
    return 6'((16'(v) * 16'd205) >> 10);
  endfunction
  assign stage = state == 4'd2 || state == 4'd4 || state == 4'd6;
  assign entry = stage && state != prev_state;
  assign any_key = key_up || key_down || key_left || key_right;
  assign step = 10'(STEP);
  assign x10 = {2'b0, player_x};
  assign y10 = {2'b0, player_y};
  assign nx = (key_up || key_down || !key_left && !key_right) ? x10 : key_left ? x10 - step : x10 + step;
  assign ny = key_up ? y10 - step : key_down ? y10 + step : y10;
  assign oob = nx[9] || ny[9] || nx + 10'(PLAYER_SIZE - 1) > 10'd204 || ny + 10'(PLAYER_SIZE - 1) > 10'd204;
  assign busy = fsm != IDLE;
  assign map_req = fsm inside {PROBE0, PROBE1, PROBE2, PROBE3};
  assign k = {fsm inside {PROBE2, PROBE3}, fsm inside {PROBE1, PROBE3}};
  assign px = cand_x + (k[0] ? 8'(PLAYER_SIZE - 1) : 8'd0);
  assign py = cand_y + (k[1] ? 8'(PLAYER_SIZE - 1) : 8'd0);
  assign map_col = map_req ? div5(px) : 6'd0;
  assign map_row = map_req ? div5(py) : 6'd0;
  always_comb begin
    fsm_nx = fsm;
    blk_nx = 1'b0;
    goal_nx = 1'b0;
    if (!stage || entry) fsm_nx = IDLE;
    else
      unique case (fsm)
        IDLE: begin
          fsm_nx = (move_tick && any_key && !oob) ? PROBE0 : IDLE;
          blk_nx = move_tick && any_key && oob;
        end
        WAIT0, WAIT1, WAIT2, WAIT3: begin
          fsm_nx = map_wall ? IDLE : fsm_t'(fsm + 4'd1);
          blk_nx = map_wall;
        end
        COMMIT: begin
          fsm_nx = IDLE;
          goal_nx = {1'b0, cand_x} + 9'(PLAYER_SIZE - 1) >= 9'(EXIT_X);
        end
        default: fsm_nx = fsm_t'(fsm + 4'd1);
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      prev_state <= 4'd0;
      player_x <= 8'(START_X);
      player_y <= 8'(START_Y);
      cand_x <= 8'd0;
      cand_y <= 8'd0;
      blocked <= 1'b0;
      goal <= 1'b0;
    end else begin
      fsm <= fsm_nx;
      prev_state <= state;
      blocked <= blk_nx;
      goal <= goal_nx;
      if (entry) begin
        player_x <= 8'(START_X);
        player_y <= 8'(START_Y);
      end else if (fsm == COMMIT && stage) begin
        player_x <= cand_x;
        player_y <= cand_y;
      end
      if (fsm == IDLE && fsm_nx == PROBE0) begin
        cand_x <= nx[7:0];
        cand_y <= ny[7:0];
      end
    end
endmodule

// File: tb/tb_player_move.sv
// tb_player_move: scoreboard bench for player_move with a behavioural map ROM stub.
module tb_player_move;
  logic clk = 0, rst_n = 0;
  logic [3:0] state = 4'd2;
  logic move_tick = 0, key_up = 0, key_down = 0, key_left = 0, key_right = 0;
  logic map_req, map_wall = 0, busy, blocked, goal;
  logic [5:0] map_row, map_col;
  logic [7:0] player_x, player_y;
  int n_checks = 0, n_fail = 0;
  int mx = 5, my = 5;
  bit wall_en = 0;
  int wr = -1, wc = -1;
  logic [11:0] req_q[$];

  player_move dut (
    .clk(clk), .rst_n(rst_n), .state(state), .move_tick(move_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .map_req(map_req), .map_row(map_row), .map_col(map_col), .map_wall(map_wall),
    .player_x(player_x), .player_y(player_y), .busy(busy), .blocked(blocked), .goal(goal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_wall(int r, int c);
    return wall_en && (wr < 0 || r == wr) && (wc < 0 || c == wc);
  endfunction

  function automatic bit is_stage(logic [3:0] s);
    return s == 4'd2 || s == 4'd4 || s == 4'd6;
  endfunction

  always @(posedge clk) map_wall <= map_req && is_wall(int'(map_row), int'(map_col));

  always @(negedge clk)
    if (map_req) begin
      if (req_q.size() == 0) check("req_extra", {20'd0, map_row, map_col}, 32'hffff_ffff);
      else check("req_rc", {20'd0, map_row, map_col}, {20'd0, req_q.pop_front()});
    end

  // reference model: pushes the probes a move should issue and predicts its outcome edges
  task automatic plan(input bit u, d, l, r, output int blk_e, done_e, goal_e, nx, ny);
    blk_e = -1; done_e = -1; goal_e = -1; nx = mx; ny = my;
    if (!is_stage(state) || !(u || d || l || r)) return;
    if (u) ny--; else if (d) ny++; else if (l) nx--; else nx++;
    if (nx < 0 || ny < 0 || nx + 3 > 204 || ny + 3 > 204) begin
      blk_e = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int cx, cy;
      cx = nx + 3 * (k % 2);
      cy = ny + 3 * (k / 2);
      req_q.push_back({6'(cy / 5), 6'(cx / 5)});
      if (is_wall(cy / 5, cx / 5)) begin
        blk_e = 2 * k + 2;
        return;
      end
    end
    done_e = 9;
    if (nx + 3 >= 200) goal_e = 9;
  endtask

  task automatic move(input bit u, d, l, r);
    int blk_e, done_e, goal_e, nx, ny, ox, oy;
    ox = mx; oy = my;
    plan(u, d, l, r, blk_e, done_e, goal_e, nx, ny);
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = {u, d, l, r};
    move_tick = 1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        move_tick = 0;
        {key_up, key_down, key_left, key_right} = 4'($urandom);
      end
      if (e == 1 && (blk_e > 0 || done_e > 0)) move_tick = 1;
      if (e == 2) move_tick = 0;
      check("blocked", blocked, e == blk_e);
      check("goal", goal, e == goal_e);
      check("x", player_x, (done_e >= 0 && e >= done_e) ? nx : ox);
      check("y", player_y, (done_e >= 0 && e >= done_e) ? ny : oy);
    end
    {key_up, key_down, key_left, key_right} = 4'd0;
    check("busy_end", busy, 0);
    check("q_empty", req_q.size(), 0);
    if (done_e > 0) begin mx = nx; my = ny; end
  endtask

  task automatic set_state(input logic [3:0] s);
    @(negedge clk);
    if (is_stage(s) && s != state) begin mx = 5; my = 5; end
    state = s;
    @(posedge clk); #1;
    check("st_x", player_x, mx);
    check("st_y", player_y, my);
    check("st_busy", busy, 0);
    check("st_pulse", {blocked, goal}, 0);
  endtask

  // launch a move that will be aborted after a given number of edges past the tick
  task automatic start_move(input bit u, d, l, r, input int edges);
    int blk_e, done_e, goal_e, nx, ny;
    plan(u, d, l, r, blk_e, done_e, goal_e, nx, ny);
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = {u, d, l, r};
    move_tick = 1;
    @(posedge clk); #1;
    move_tick = 0;
    {key_up, key_down, key_left, key_right} = 4'd0;
    repeat (edges) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_x", player_x, 5);
    check("rst_y", player_y, 5);
    check("rst_busy", busy, 0);
    check("rst_req", map_req, 0);
    check("rst_rc", {map_row, map_col}, 0);
    check("rst_pulse", {blocked, goal}, 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    wall_en = 1; wr = 0; wc = -1;
    move(1, 0, 0, 0);
    wall_en = 0;
    move(0, 0, 0, 1);
    move(1, 0, 0, 1);
    repeat (5) move(1, 0, 0, 0);
    wall_en = 1; wr = -1; wc = 2;
    move(0, 0, 0, 1);
    wall_en = 0;
    move(0, 1, 0, 0);
    wall_en = 1; wr = 1; wc = 1;
    move(0, 1, 0, 0);
    wall_en = 0;
    move(0, 0, 0, 1);
    wall_en = 1; wr = 1; wc = 2;
    move(0, 1, 0, 0);
    wall_en = 0;
    set_state(4'd0);
    move(0, 0, 0, 1);
    set_state(4'd4);
    while (mx < 201) move(0, 0, 0, 1);
    move(0, 0, 0, 1);
    move(0, 1, 0, 0);
    // asynchronous reset in the middle of a probe sequence
    start_move(0, 0, 1, 0, 3);
    #2 rst_n = 0;
    #1;
    check("t1_x", player_x, 5);
    check("t1_y", player_y, 5);
    check("t1_busy", busy, 0);
    check("t1_req", map_req, 0);
    check("t1_pulse", {blocked, goal}, 0);
    check("t1_q", req_q.size(), 2);
    req_q.delete();
    mx = 5; my = 5;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("t1_rel", {player_x, player_y}, {8'd5, 8'd5});
    set_state(4'd2);
    move(0, 0, 0, 1);
    move(0, 1, 0, 0);
    // stage change during PROBE2 aborts and reloads
    start_move(0, 0, 0, 1, 4);
    #2 state = 4'd4;
    @(posedge clk); #1;
    check("t6_q", req_q.size(), 1);
    check("t6_x", player_x, 5);
    check("t6_y", player_y, 5);
    check("t6_busy", busy, 0);
    req_q.delete();
    mx = 5; my = 5;
    for (int i = 0; i < 4; i++) begin
      check("t6_pulse", {blocked, goal}, 0);
      @(posedge clk); #1;
    end
    move(0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
